// File: rtl/nmos_pmos_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nmos_pmos_pkg
// Brief    : Shared widths and ALU opcodes for the nmos_pmos register-file
//            calculator.
// Revision : 1.0 - initial release
// ============================================================================
package nmos_pmos_pkg;

    localparam int DATA_W = 4;
    localparam int ADDR_W = 2;
    localparam int NREG   = 4;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_AND2 = 3'b011;
    localparam logic [2:0] OP_ANDN = 3'b100;
    localparam logic [2:0] OP_ORN  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

endpackage
`default_nettype wire

// File: rtl/nmos_pmos_alu.sv
`default_nettype none
// ============================================================================
// Module   : nmos_pmos_alu
// Brief    : Combinational 8-operation 4-bit ALU. Signed SLT on opcode 111 is
//            built only when NMOS_PMOS_SLT_EN is defined; otherwise it yields 0.
// Revision : 1.0 - initial release
// ============================================================================
module nmos_pmos_alu
    import nmos_pmos_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] y
);

`ifdef NMOS_PMOS_SLT_EN
    // Sign-extend to 5 bits so the difference sign is correct on overflow.
    logic [DATA_W:0] slt_diff;
    assign slt_diff = {a[DATA_W-1], a} - {b[DATA_W-1], b};
`endif

    always_comb begin
        y = '0;
        case (op)
            OP_AND, OP_AND2: y = a & b;
            OP_OR:           y = a | b;
            OP_ADD:          y = a + b;
            OP_ANDN:         y = a & ~b;
            OP_ORN:          y = a | ~b;
            OP_SUB:          y = a + ~b + DATA_W'(1);
`ifdef NMOS_PMOS_SLT_EN
            OP_SLT:          y = {{(DATA_W-1){1'b0}}, slt_diff[DATA_W]};
`else
            OP_SLT:          y = '0;
`endif
            default:         y = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/nmos_pmos.sv
`default_nettype none
// ============================================================================
// Module   : nmos_pmos
// Brief    : Four 4-bit registers feeding an ALU; the result is written back on
//            every falling clock edge. Option macro: NMOS_PMOS_SLT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module nmos_pmos
    import nmos_pmos_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] immediate,
    input  logic [ADDR_W-1:0] we_addr,
    input  logic [2:0]        control,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [DATA_W-1:0] alu_y;

    assign rd_data = regs_q[rd_addr];

    nmos_pmos_alu u_alu (
        .a  (rd_data),
        .b  (immediate),
        .op (control),
        .y  (alu_y)
    );

    // No write enable: the addressed register always takes the ALU result.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = (we_addr == ADDR_W'(i)) ? alu_y : regs_q[i];
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nmos_pmos.sv
`default_nettype none
// ============================================================================
// Module   : tb_nmos_pmos
// Brief    : Directed self-checking bench for the nmos_pmos calculator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nmos_pmos;
    import nmos_pmos_pkg::*;

`ifdef NMOS_PMOS_SLT_EN
    localparam logic SLT_ON = 1'b1;
`else
    localparam logic SLT_ON = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] immediate;
    logic [ADDR_W-1:0] we_addr;
    logic [2:0]        control;
    logic [DATA_W-1:0] rd_data;

    int n_checks = 0;
    int n_errors = 0;

    nmos_pmos dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr   (rd_addr),
        .immediate (immediate),
        .we_addr   (we_addr),
        .control   (control),
        .rd_data   (rd_data)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                            input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Apply one operation, let the falling edge write it, then read back the destination.
    task automatic op_check(input string tag, input logic [ADDR_W-1:0] rd,
                            input logic [ADDR_W-1:0] we, input logic [2:0] ctl,
                            input logic [DATA_W-1:0] imm, input logic [DATA_W-1:0] exp);
        rd_addr   = rd;
        we_addr   = we;
        control   = ctl;
        immediate = imm;
        @(negedge clk);
        #1;
        rd_addr = we;
        #1;
        check_eq(tag, rd_data, exp);
    endtask

    task automatic read_check(input string tag, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] exp);
        rd_addr = addr;
        #1;
        check_eq(tag, rd_data, exp);
    endtask

    logic [DATA_W-1:0] acc_exp [6];
    logic [DATA_W-1:0] slt_one;

    initial begin
        acc_exp = '{4'd3, 4'd6, 4'd9, 4'd12, 4'd15, 4'd2};
        slt_one = SLT_ON ? 4'b0001 : 4'b0000;

        rst_n     = 1'b1;
        rd_addr   = '0;
        we_addr   = '0;
        control   = OP_OR;
        immediate = 4'b1111;
        #1 rst_n  = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < NREG; i++) begin
            read_check($sformatf("reset_r%0d", i), ADDR_W'(i), 4'd0);
        end

        @(posedge clk);
        #1;
        rd_addr   = 2'd1;
        we_addr   = 2'd1;
        control   = OP_ADD;
        immediate = 4'd3;
        rst_n     = 1'b1;
        for (int i = 0; i < 6; i++) begin
            op_check($sformatf("accum_%0d", i), 2'd1, 2'd1, OP_ADD, 4'd3, acc_exp[i]);
        end

        op_check("load_r0",  2'd0, 2'd0, OP_OR,   4'b1100, 4'b1100);
        op_check("op_and",   2'd0, 2'd3, OP_AND,  4'b1010, 4'b1000);
        op_check("op_andn",  2'd0, 2'd3, OP_ANDN, 4'b1010, 4'b0100);
        op_check("op_orn",   2'd0, 2'd3, OP_ORN,  4'b1010, 4'b1101);
        op_check("op_and2",  2'd0, 2'd3, OP_AND2, 4'b1010, 4'b1000);

        op_check("load_r2",  2'd2, 2'd2, OP_OR,   4'b0010, 4'b0010);
        op_check("op_sub",   2'd2, 2'd3, OP_SUB,  4'b0101, 4'b1101);
        op_check("slt_lt",   2'd2, 2'd3, OP_SLT,  4'b0101, slt_one);
        op_check("slt_neg",  2'd2, 2'd3, OP_SLT,  4'b1110, 4'b0000);
        op_check("clr_r2",   2'd2, 2'd2, OP_AND,  4'b0000, 4'b0000);
        op_check("load_m8",  2'd2, 2'd2, OP_OR,   4'b1000, 4'b1000);
        op_check("slt_ovf",  2'd2, 2'd3, OP_SLT,  4'b0111, slt_one);

        op_check("clr_r0",   2'd0, 2'd0, OP_AND,  4'b0000, 4'b0000);
        op_check("load_r0_5", 2'd0, 2'd0, OP_OR,  4'b0101, 4'b0101);
        op_check("cross_r3", 2'd0, 2'd3, OP_ADD,  4'b0001, 4'b0110);
        read_check("cross_r0_hold", 2'd0, 4'b0101);
        read_check("cross_r2_own",  2'd2, 4'b1000);
        read_check("cross_r1_own",  2'd1, 4'b0010);

        // Reset asserted while clk is high; the following falling edge must not write.
        @(posedge clk);
        #1;
        rd_addr   = 2'd0;
        we_addr   = 2'd0;
        control   = OP_OR;
        immediate = 4'b1111;
        rst_n     = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            read_check($sformatf("midreset_r%0d", i), ADDR_W'(i), 4'd0);
        end
        rd_addr = 2'd0;
        @(negedge clk);
        #1;
        check_eq("midreset_nowrite", rd_data, 4'd0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        op_check("post_release", 2'd0, 2'd0, OP_OR, 4'b1111, 4'b1111);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
